// File: rtl/hamming_secded_shiftreg.sv
// hamming_secded_shiftreg: shift/load register stored as SECDED (8,4) codewords, one per nibble,
// with a background scrubber that writes back single-bit corrections and counts errors.
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   enable, mode, load       shift/load step control (00 SISO right, 01 SISO left, 10 PISO, 11 PIPO)
//   serial_in, parallel_in   step data inputs
//   serial_out               data bit 0 in modes 00/10, data bit WIDTH-1 in modes 01/11
//   parallel_out             corrected view of stored data (combinational)
//   scrub_req                start one scrub pass (IDLE and enable=0 only)
//   scrub_busy, scrub_done   pass running / one-cycle completion pulse
//   sec_count, ded_count     saturating corrected / uncorrectable counts from scrubbing
//   ded_flag                 sticky uncorrectable-error flag
//   clr_stats                clears counters and ded_flag
//
// Optional: define HAMMING_ERR_INJ_EN to add inj_valid, inj_data_mask and inj_chk_mask, which XOR
// error masks into storage while idle. Check bits of block i sit at 4i..4i+3 as p1, p2, p3, p0.
module hamming_secded_shiftreg #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [1:0]           mode,
  input  logic                 load,
  input  logic                 serial_in,
  input  logic [WIDTH-1:0]     parallel_in,
  output logic                 serial_out,
  output logic [WIDTH-1:0]     parallel_out,
  input  logic                 scrub_req,
  output logic                 scrub_busy,
  output logic                 scrub_done,
  output logic [CNT_W-1:0]     sec_count,
  output logic [CNT_W-1:0]     ded_count,
  output logic                 ded_flag,
`ifdef HAMMING_ERR_INJ_EN
  input  logic                 inj_valid,
  input  logic [WIDTH-1:0]     inj_data_mask,
  input  logic [WIDTH-1:0]     inj_chk_mask,
`endif
  input  logic                 clr_stats
);

  localparam int unsigned BLOCKS = WIDTH / 4;
  localparam int unsigned IdxW   = (BLOCKS > 1) ? $clog2(BLOCKS) : 1;

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

  // Check nibble layout: [0]=p1, [1]=p2, [2]=p3, [3]=p0 (overall parity).
  function automatic logic [3:0] encode(input logic [3:0] d);
    logic p1, p2, p3;
    p1 = d[0] ^ d[2] ^ d[3];
    p2 = d[0] ^ d[1] ^ d[3];
    p3 = d[0] ^ d[1] ^ d[2];
    return {(^d) ^ p1 ^ p2 ^ p3, p3, p2, p1};
  endfunction

  // Returns {single, double, data}. Data is corrected only for a single error; an error in a
  // check bit needs no data flip, and check bits are always re-encoded on write-back.
  function automatic logic [5:0] decode(input logic [3:0] d, input logic [3:0] c);
    logic [2:0] syn;
    logic       q;
    logic [3:0] flip;
    syn[0] = c[0] ^ d[3] ^ d[2] ^ d[0];
    syn[1] = c[1] ^ d[3] ^ d[1] ^ d[0];
    syn[2] = c[2] ^ d[2] ^ d[1] ^ d[0];
    q      = c[3] ^ (^d) ^ c[0] ^ c[1] ^ c[2];
    case (syn)
      3'b101:  flip = 4'b0100;
      3'b111:  flip = 4'b0001;
      3'b011:  flip = 4'b1000;
      3'b110:  flip = 4'b0010;
      default: flip = 4'b0000;
    endcase
    return {q, ~q & (|syn), q ? (d ^ flip) : d};
  endfunction

  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] chk_q, chk_d;
  state_e           state_q, state_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0] sec_q, sec_d, ded_q, ded_d;
  logic             flag_q, flag_d;

  logic [WIDTH-1:0]  corr_data;
  logic [BLOCKS-1:0] blk_single, blk_double;
  logic [WIDTH-1:0]  step_data;
  logic              sec_inc, ded_inc;

  always_comb begin
    corr_data  = data_q;
    blk_single = '0;
    blk_double = '0;
    for (int unsigned b = 0; b < BLOCKS; b++) begin
      {blk_single[b], blk_double[b], corr_data[4*b +: 4]} =
          decode(data_q[4*b +: 4], chk_q[4*b +: 4]);
    end
  end

  assign parallel_out = corr_data;
  assign serial_out   = mode[0] ? data_q[WIDTH-1] : data_q[0];
  assign scrub_busy   = (state_q != StIdle);
  assign scrub_done   = (state_q == StDone);
  assign sec_count    = sec_q;
  assign ded_count    = ded_q;
  assign ded_flag     = flag_q;

  // Steps shift the corrected view, so a latent single error never propagates.
  always_comb begin
    step_data = corr_data;
    unique case (mode)
      2'b00: step_data = {serial_in, corr_data[WIDTH-1:1]};
      2'b01: step_data = {corr_data[WIDTH-2:0], serial_in};
      2'b10: step_data = load ? parallel_in : {1'b0, corr_data[WIDTH-1:1]};
      2'b11: step_data = load ? parallel_in : corr_data;
      default: step_data = corr_data;
    endcase
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    chk_d   = chk_q;
    sec_inc = 1'b0;
    ded_inc = 1'b0;
    if (enable) begin
      // A step aborts any pass in flight; that cycle's scrub result is discarded.
      data_d  = step_data;
      for (int unsigned b = 0; b < BLOCKS; b++) begin
        chk_d[4*b +: 4] = encode(step_data[4*b +: 4]);
      end
      state_d = StIdle;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (scrub_req) begin
            state_d = StScan;
            idx_d   = '0;
          end
        end
        StScan: begin
          for (int unsigned b = 0; b < BLOCKS; b++) begin
            if (idx_q == IdxW'(b)) begin
              if (blk_single[b]) begin
                data_d[4*b +: 4] = corr_data[4*b +: 4];
                chk_d[4*b +: 4]  = encode(corr_data[4*b +: 4]);
                sec_inc          = 1'b1;
              end else if (blk_double[b]) begin
                ded_inc = 1'b1;
              end
            end
          end
          if (idx_q == IdxW'(BLOCKS - 1)) begin
            state_d = StDone;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
        StDone: state_d = StIdle;
        default: state_d = StIdle;
      endcase
`ifdef HAMMING_ERR_INJ_EN
      if (inj_valid && (state_q == StIdle)) begin
        data_d = data_q ^ inj_data_mask;
        chk_d  = chk_q ^ inj_chk_mask;
      end
`endif
    end
  end

  always_comb begin
    sec_d  = sec_q;
    ded_d  = ded_q;
    flag_d = flag_q;
    if (clr_stats) begin
      sec_d  = '0;
      ded_d  = '0;
      flag_d = 1'b0;
    end else begin
      if (sec_inc && !(&sec_q)) sec_d = sec_q + 1'b1;
      if (ded_inc && !(&ded_q)) ded_d = ded_q + 1'b1;
      if (ded_inc)              flag_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      chk_q   <= '0;
      state_q <= StIdle;
      idx_q   <= '0;
      sec_q   <= '0;
      ded_q   <= '0;
      flag_q  <= 1'b0;
    end else begin
      data_q  <= data_d;
      chk_q   <= chk_d;
      state_q <= state_d;
      idx_q   <= idx_d;
      sec_q   <= sec_d;
      ded_q   <= ded_d;
      flag_q  <= flag_d;
    end
  end

endmodule

// File: tb/tb_hamming_secded_shiftreg.sv
// Bench for hamming_secded_shiftreg (WIDTH=8, CNT_W=4): table-driven step vectors with a
// scoreboard queue, then hand-written scrub, injection, abort and saturation sequences.
module tb_hamming_secded_shiftreg;

  localparam int unsigned W   = 8;
  localparam int unsigned CW  = 4;
  localparam int unsigned B   = W / 4;

  logic          clk = 1'b0;
  logic          rst, enable, load, serial_in, scrub_req, clr_stats;
  logic [1:0]    mode;
  logic [W-1:0]  parallel_in;
  logic          serial_out, scrub_busy, scrub_done, ded_flag;
  logic [W-1:0]  parallel_out;
  logic [CW-1:0] sec_count, ded_count;
`ifdef HAMMING_ERR_INJ_EN
  logic          inj_valid;
  logic [W-1:0]  inj_data_mask, inj_chk_mask;
`else
  logic [W-1:0]  force_d, force_c;
`endif

  int checks = 0;
  int errors = 0;

  hamming_secded_shiftreg #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .mode         (mode),
    .load         (load),
    .serial_in    (serial_in),
    .parallel_in  (parallel_in),
    .serial_out   (serial_out),
    .parallel_out (parallel_out),
    .scrub_req    (scrub_req),
    .scrub_busy   (scrub_busy),
    .scrub_done   (scrub_done),
    .sec_count    (sec_count),
    .ded_count    (ded_count),
    .ded_flag     (ded_flag),
`ifdef HAMMING_ERR_INJ_EN
    .inj_valid    (inj_valid),
    .inj_data_mask(inj_data_mask),
    .inj_chk_mask (inj_chk_mask),
`endif
    .clr_stats    (clr_stats)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         en;
    logic [1:0]   mode;
    logic         load;
    logic         sin;
    logic [W-1:0] pin;
    logic [W-1:0] exp_pout;
    logic         exp_sout;
  } vec_t;

  typedef struct {
    logic [W-1:0] pout;
    logic         sout;
  } exp_t;

  vec_t vecs[9];
  exp_t sb[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic inject(input logic [W-1:0] dm, input logic [W-1:0] cm);
`ifdef HAMMING_ERR_INJ_EN
    inj_valid     = 1'b1;
    inj_data_mask = dm;
    inj_chk_mask  = cm;
    tick();
    inj_valid     = 1'b0;
    inj_data_mask = '0;
    inj_chk_mask  = '0;
`else
    force_d = dut.data_q ^ dm;
    force_c = dut.chk_q ^ cm;
    force dut.data_q = force_d;
    force dut.chk_q  = force_c;
    tick();
    release dut.data_q;
    release dut.chk_q;
`endif
  endtask

  // Full pass: expect B+1 busy cycles with scrub_done only in the last one.
  task automatic do_scrub(input string tag);
    int busy_n = 0;
    int done_at = 0;
    int done_n = 0;
    scrub_req = 1'b1;
    tick();
    scrub_req = 1'b0;
    for (int c = 0; c < 40 && scrub_busy; c++) begin
      busy_n++;
      if (scrub_done) begin
        done_n++;
        done_at = busy_n;
      end
      tick();
    end
    check({tag, " busy_cycles"}, busy_n, B + 1);
    check({tag, " done_pos"}, done_at, B + 1);
    check({tag, " done_pulses"}, done_n, 1);
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; mode = 2'b00; load = 1'b0; serial_in = 1'b0;
    parallel_in = '0; scrub_req = 1'b0; clr_stats = 1'b0;
`ifdef HAMMING_ERR_INJ_EN
    inj_valid = 1'b0; inj_data_mask = '0; inj_chk_mask = '0;
`endif
    //          en    mode   ld    sin   pin    pout   sout
    vecs[0] = '{1'b1, 2'b11, 1'b1, 1'b0, 8'hA5, 8'hA5, 1'b1};
    vecs[1] = '{1'b1, 2'b00, 1'b0, 1'b1, 8'h00, 8'hD2, 1'b0};
    vecs[2] = '{1'b1, 2'b01, 1'b0, 1'b0, 8'h00, 8'hA4, 1'b1};
    vecs[3] = '{1'b1, 2'b10, 1'b0, 1'b1, 8'hFF, 8'h52, 1'b0};
    vecs[4] = '{1'b1, 2'b10, 1'b1, 1'b0, 8'h3C, 8'h3C, 1'b0};
    vecs[5] = '{1'b1, 2'b11, 1'b0, 1'b1, 8'hFF, 8'h3C, 1'b0};
    vecs[6] = '{1'b1, 2'b01, 1'b0, 1'b1, 8'h00, 8'h79, 1'b0};
    vecs[7] = '{1'b1, 2'b00, 1'b0, 1'b0, 8'h00, 8'h3C, 1'b0};
    vecs[8] = '{1'b0, 2'b00, 1'b1, 1'b1, 8'hFF, 8'h3C, 1'b0};

    tick();
    tick();
    rst = 1'b0;
    check("rst pout", parallel_out, 0);
    check("rst sout", serial_out, 0);
    check("rst busy", scrub_busy, 0);
    check("rst done", scrub_done, 0);
    check("rst sec", sec_count, 0);
    check("rst ded", ded_count, 0);
    check("rst flag", ded_flag, 0);

    for (int i = 0; i < 9; i++) begin
      enable = vecs[i].en; mode = vecs[i].mode; load = vecs[i].load;
      serial_in = vecs[i].sin; parallel_in = vecs[i].pin;
      sb.push_back('{vecs[i].exp_pout, vecs[i].exp_sout});
      tick();
      begin
        exp_t e;
        e = sb.pop_front();
        check($sformatf("vec%0d pout", i), parallel_out, e.pout);
        check($sformatf("vec%0d sout", i), serial_out, e.sout);
      end
    end
    enable = 1'b0; load = 1'b0; serial_in = 1'b0;

    // Clean pass over a freshly loaded word.
    enable = 1'b1; mode = 2'b11; load = 1'b1; parallel_in = 8'hA5;
    tick();
    enable = 1'b0; load = 1'b0;
    check("load A5", parallel_out, 8'hA5);
    do_scrub("clean");
    check("clean sec", sec_count, 0);
    check("clean ded", ded_count, 0);

    // Single data error in block 0: masked on the output, repaired by scrub.
    inject(8'h04, 8'h00);
    check("sec pout", parallel_out, 8'hA5);
    check("sec raw", dut.data_q, 8'hA1);
    do_scrub("sec");
    check("sec raw fixed", dut.data_q, 8'hA5);
    check("sec count", sec_count, 1);

    // Double error in block 1: left alone, raw nibble shows through.
    inject(8'h30, 8'h00);
    check("ded pout", parallel_out, 8'h95);
    do_scrub("ded");
    check("ded count", ded_count, 1);
    check("ded flag", ded_flag, 1);
    check("ded sec", sec_count, 1);
    check("ded pout after", parallel_out, 8'h95);
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    check("clr sec", sec_count, 0);
    check("clr ded", ded_count, 0);
    check("clr flag", ded_flag, 0);

    // Overall parity bit of block 0 only.
    enable = 1'b1; mode = 2'b11; load = 1'b1; parallel_in = 8'hA5;
    tick();
    enable = 1'b0; load = 1'b0;
    inject(8'h00, 8'h08);
    check("p0 pout", parallel_out, 8'hA5);
    do_scrub("p0");
    check("p0 sec", sec_count, 1);
    do_scrub("p0 recheck");
    check("p0 recheck sec", sec_count, 1);
    check("p0 recheck ded", ded_count, 0);

    // Step during a pass (idx=1) aborts it without a done pulse.
    scrub_req = 1'b1;
    tick();
    scrub_req = 1'b0;
    tick();
    check("abort busy before", scrub_busy, 1);
    enable = 1'b1; mode = 2'b00; serial_in = 1'b0;
    tick();
    enable = 1'b0;
    check("abort busy", scrub_busy, 0);
    check("abort done", scrub_done, 0);
    check("abort pout", parallel_out, 8'h52);
    begin
      int seen = 0;
      for (int c = 0; c < 4; c++) begin
        if (scrub_done || scrub_busy) seen++;
        tick();
      end
      check("abort quiet", seen, 0);
    end

    // Saturation of sec_count.
    for (int k = 0; k < 17; k++) begin
      inject(8'h01, 8'h00);
      do_scrub($sformatf("sat%0d", k));
    end
    check("sat sec", sec_count, 15);
    check("sat raw", dut.data_q, 8'h52);

    // clr_stats in the same cycle as a correction wins.
    inject(8'h01, 8'h00);
    scrub_req = 1'b1;
    tick();
    scrub_req = 1'b0;
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    check("clr+sec count", sec_count, 0);
    check("clr+sec raw", dut.data_q, 8'h52);
    for (int c = 0; c < 10 && scrub_busy; c++) tick();
    check("clr+sec idle", scrub_busy, 0);
    check("clr+sec final", sec_count, 0);

    // Reset mid-pass drops it.
    scrub_req = 1'b1;
    tick();
    scrub_req = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst busy", scrub_busy, 0);
    check("midrst done", scrub_done, 0);
    check("midrst pout", parallel_out, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
